sd_cmd_sched: RTL and testbench

//  Shares the sd_cmd engine between two requesters: port 0 (register/CPU) and port 1 (data engine, e.g. CMD12/CMD13).

---
 rtl/sd_cmd_sched.sv | 262 ++++++++++++++++++++++++++
 tb/tb_sd_cmd_sched.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_sched.sv
// ---------------------------------------------------------------------------
// sd_cmd_sched
//
// Purpose:
//   Shares one sd_cmd engine between two requesters. Port 0 is the
//   register/CPU side and port 1 is the data engine (CMD12/CMD13 and
//   similar). The scheduler:
//   - arbitrates between the two ports, alternating on ties;
//   - computes CRC7 serially over the 40 header bits;
//   - assembles the 48-bit frame into o_cb and issues it with a one-clock
//     o_cmd_pending pulse;
//   - retries response timeouts up to MAX_RETRY extra times;
//   - waits GUARD_EDGES SD clock rising edges after every ack before the
//     engine is used again;
//   - returns the final status and response to the port that owns it.
//
// Parameters:
//   MAX_RETRY    extra attempts after a timeout status (0 = never retry)
//   GUARD_EDGES  SD clock rising edges to wait after each ack (covers Nrc)
//
// Ports:
//   i_clk              host clock
//   i_reset            synchronous, active-high reset
//   i_sd_clk_rising    one-clk strobe marking each SD clock rising edge
//   i_reqN_valid       N=0,1: request, held with fields stable until done
//   i_reqN_idx         N=0,1: 6-bit command index
//   i_reqN_arg         N=0,1: 32-bit command argument
//   i_reqN_resp_len    N=0,1: 0x none, 10 48-bit, 11 136-bit response
//   o_reqN_done        N=0,1: one-clk pulse, request complete, o_res_* valid
//   o_res_status       final status: 00 ok, 01 timeout, 10 end-bit, 11 CRC
//   o_res_rb           captured 128-bit response
//   o_res_owner        port that owns o_res_*
//   o_res_retries      retries used, saturating at 3
//   o_busy             scheduler is not idle
//   o_cb               frame to sd_cmd, stable from issue until ack
//   o_cmd_resp_len     response length to sd_cmd
//   o_cmd_pending      one-clk issue pulse to sd_cmd
//   i_cmd_ack          from sd_cmd, toggles on every completion
//   i_cmd_status       status from sd_cmd
//   i_rb               response from sd_cmd
// ---------------------------------------------------------------------------
module sd_cmd_sched #(
  parameter int MAX_RETRY   = 3,
  parameter int GUARD_EDGES = 9
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_sd_clk_rising,
  input  logic         i_req0_valid,
  input  logic [5:0]   i_req0_idx,
  input  logic [31:0]  i_req0_arg,
  input  logic [1:0]   i_req0_resp_len,
  input  logic         i_req1_valid,
  input  logic [5:0]   i_req1_idx,
  input  logic [31:0]  i_req1_arg,
  input  logic [1:0]   i_req1_resp_len,
  output logic         o_req0_done,
  output logic         o_req1_done,
  output logic [1:0]   o_res_status,
  output logic [127:0] o_res_rb,
  output logic         o_res_owner,
  output logic [1:0]   o_res_retries,
  output logic         o_busy,
  output logic [47:0]  o_cb,
  output logic [1:0]   o_cmd_resp_len,
  output logic         o_cmd_pending,
  input  logic         i_cmd_ack,
  input  logic [1:0]   i_cmd_status,
  input  logic [127:0] i_rb
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CRC   = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] GUARD = 3'd4;

  localparam logic [7:0]  MAX_RETRY_W = 8'(MAX_RETRY);
  localparam logic [15:0] GUARD_LAST  = 16'(GUARD_EDGES - 1);
  localparam bit          GUARD_NONE  = (GUARD_EDGES == 0);

  logic [2:0]   r_state;
  logic         r_owner;
  logic         r_last_owner;
  logic [5:0]   r_idx;
  logic [31:0]  r_arg;
  logic [1:0]   r_resp_len;
  logic [6:0]   r_crc;
  logic [5:0]   r_bit_cnt;
  logic [7:0]   r_retry_cnt;
  logic         r_pending_retry;
  logic [15:0]  r_guard_cnt;
  logic         r_ack_seen;
  logic         r_done0;
  logic         r_done1;
  logic [47:0]  r_cb;
  logic [1:0]   r_res_status;
  logic [127:0] r_res_rb;
  logic         r_res_owner;
  logic [1:0]   r_res_retries;

  logic         w_any_done;
  logic         w_grant;
  logic         w_grant_port;
  logic [5:0]   w_sel_idx;
  logic [31:0]  w_sel_arg;
  logic [1:0]   w_sel_resp_len;
  logic [39:0]  w_frame;
  logic         w_bit;
  logic         w_fb;
  logic [6:0]   w_crc_next;
  logic         w_crc_last;
  logic         w_ack_event;
  logic         w_retry_ok;
  logic         w_guard_exit;
  logic [1:0]   w_retries_sat;

  // Arbitration. A done pulse blocks granting for that one clock so a
  // requester that has not yet dropped valid is not served twice. On a tie
  // the port that was not served last wins; after reset that is port 1.
  always_comb begin
    w_any_done   = r_done0 | r_done1;
    w_grant      = !w_any_done && (i_req0_valid || i_req1_valid);
    w_grant_port = (i_req0_valid && i_req1_valid) ? ~r_last_owner : i_req1_valid;
    if (w_grant_port) begin
      w_sel_idx      = i_req1_idx;
      w_sel_arg      = i_req1_arg;
      w_sel_resp_len = i_req1_resp_len;
    end else begin
      w_sel_idx      = i_req0_idx;
      w_sel_arg      = i_req0_arg;
      w_sel_resp_len = i_req0_resp_len;
    end
  end

  // Serial CRC7 (x^7 + x^3 + 1) over start bit, transmission bit, index and
  // argument, MSB first. The last step's result goes straight into the
  // frame so no extra clock is spent after the 40th bit.
  always_comb begin
    w_frame    = {1'b0, 1'b1, r_idx, r_arg};
    w_bit      = w_frame[6'd39 - r_bit_cnt];
    w_fb       = w_bit ^ r_crc[6];
    w_crc_next = {r_crc[5:0], 1'b0} ^ (w_fb ? 7'h09 : 7'h00);
    w_crc_last = (r_bit_cnt == 6'd39);
  end

  // Completion and retry decisions. The ack is a toggle, so any difference
  // from the value captured at issue marks a completion. Only a timeout is
  // retried; every other status completes immediately.
  always_comb begin
    w_ack_event   = (i_cmd_ack != r_ack_seen);
    w_retry_ok    = (i_cmd_status == 2'b01) && (r_retry_cnt < MAX_RETRY_W);
    w_guard_exit  = GUARD_NONE || (i_sd_clk_rising && (r_guard_cnt == GUARD_LAST));
    w_retries_sat = (r_retry_cnt > 8'd3) ? 2'd3 : r_retry_cnt[1:0];
  end

  // Main sequencer. Reset drops any command in flight without a done pulse
  // and resynchronises the ack tracker to the engine's current toggle level.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= IDLE;
      r_owner         <= 1'b0;
      r_last_owner    <= 1'b0;
      r_idx           <= 6'd0;
      r_arg           <= 32'd0;
      r_resp_len      <= 2'd0;
      r_crc           <= 7'd0;
      r_bit_cnt       <= 6'd0;
      r_retry_cnt     <= 8'd0;
      r_pending_retry <= 1'b0;
      r_guard_cnt     <= 16'd0;
      r_ack_seen      <= i_cmd_ack;
      r_done0         <= 1'b0;
      r_done1         <= 1'b0;
      r_cb            <= 48'd0;
      r_res_status    <= 2'd0;
      r_res_rb        <= 128'd0;
      r_res_owner     <= 1'b0;
      r_res_retries   <= 2'd0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner         <= w_grant_port;
            r_idx           <= w_sel_idx;
            r_arg           <= w_sel_arg;
            r_resp_len      <= w_sel_resp_len;
            r_crc           <= 7'd0;
            r_bit_cnt       <= 6'd0;
            r_retry_cnt     <= 8'd0;
            r_pending_retry <= 1'b0;
            r_state         <= CRC;
          end
        end
        CRC: begin
          r_crc     <= w_crc_next;
          r_bit_cnt <= r_bit_cnt + 6'd1;
          if (w_crc_last) begin
            r_cb    <= {2'b01, r_idx, r_arg, w_crc_next, 1'b1};
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_ack_seen      <= i_cmd_ack;
          r_pending_retry <= 1'b0;
          r_state         <= WAIT;
        end
        WAIT: begin
          if (w_ack_event) begin
            r_ack_seen  <= i_cmd_ack;
            r_guard_cnt <= 16'd0;
            if (w_retry_ok) begin
              r_retry_cnt     <= r_retry_cnt + 8'd1;
              r_pending_retry <= 1'b1;
            end else begin
              r_res_status  <= i_cmd_status;
              r_res_rb      <= i_rb;
              r_res_owner   <= r_owner;
              r_res_retries <= w_retries_sat;
            end
            r_state <= GUARD;
          end
        end
        GUARD: begin
          if (w_guard_exit) begin
            if (r_pending_retry) begin
              r_state <= ISSUE;
            end else begin
              r_last_owner <= r_owner;
              r_done0      <= ~r_owner;
              r_done1      <= r_owner;
              r_state      <= IDLE;
            end
          end else if (i_sd_clk_rising) begin
            r_guard_cnt <= r_guard_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Output mapping. Pending and busy decode directly from the state so the
  // issue pulse is exactly the single clock spent in ISSUE.
  always_comb begin
    o_req0_done    = r_done0;
    o_req1_done    = r_done1;
    o_res_status   = r_res_status;
    o_res_rb       = r_res_rb;
    o_res_owner    = r_res_owner;
    o_res_retries  = r_res_retries;
    o_busy         = (r_state != IDLE);
    o_cb           = r_cb;
    o_cmd_resp_len = r_resp_len;
    o_cmd_pending  = (r_state == ISSUE);
  end

endmodule

// File: tb/tb_sd_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_sd_cmd_sched
//
// Purpose:
//   Directed bench for sd_cmd_sched. A small sd_cmd stand-in answers every
//   issue pulse after a fixed delay by toggling the ack, and a free-running
//   strobe provides an SD clock rising edge every fourth host clock.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_sd_cmd_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         sdRising;
  logic         req0Valid;
  logic [5:0]   req0Idx;
  logic [31:0]  req0Arg;
  logic [1:0]   req0RespLen;
  logic         req1Valid;
  logic [5:0]   req1Idx;
  logic [31:0]  req1Arg;
  logic [1:0]   req1RespLen;
  logic         req0Done;
  logic         req1Done;
  logic [1:0]   resStatus;
  logic [127:0] resRb;
  logic         resOwner;
  logic [1:0]   resRetries;
  logic         busy;
  logic [47:0]  cb;
  logic [1:0]   cmdRespLen;
  logic         cmdPending;
  logic         cmdAck;
  logic [1:0]   cmdStatus;
  logic [127:0] rbIn;

  int           checks = 0;
  int           failures = 0;
  int           sdEdges = 0;
  int           pendCount = 0;
  int           pendEdge [16];
  int           ackEdge [16];
  logic [47:0]  pendCb [16];
  logic         timeoutAll = 1'b0;
  logic [1:0]   modelStatus = 2'b00;
  logic [127:0] modelRb = 128'd0;
  int           respDelay = 20;

  always #5 clk = ~clk;

  sd_cmd_sched #(.MAX_RETRY(3), .GUARD_EDGES(9)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_sd_clk_rising (sdRising),
    .i_req0_valid    (req0Valid),
    .i_req0_idx      (req0Idx),
    .i_req0_arg      (req0Arg),
    .i_req0_resp_len (req0RespLen),
    .i_req1_valid    (req1Valid),
    .i_req1_idx      (req1Idx),
    .i_req1_arg      (req1Arg),
    .i_req1_resp_len (req1RespLen),
    .o_req0_done     (req0Done),
    .o_req1_done     (req1Done),
    .o_res_status    (resStatus),
    .o_res_rb        (resRb),
    .o_res_owner     (resOwner),
    .o_res_retries   (resRetries),
    .o_busy          (busy),
    .o_cb            (cb),
    .o_cmd_resp_len  (cmdRespLen),
    .o_cmd_pending   (cmdPending),
    .i_cmd_ack       (cmdAck),
    .i_cmd_status    (cmdStatus),
    .i_rb            (rbIn)
  );

  // SD clock rising-edge strobe: one host clock high out of every four.
  initial begin
    sdRising = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      sdRising = 1'b1;
      sdEdges++;
      @(negedge clk);
      sdRising = 1'b0;
    end
  end

  // sd_cmd stand-in: records each issue pulse, then after respDelay clocks
  // presents a status and response and toggles the ack.
  initial begin
    cmdAck    = 1'b0;
    cmdStatus = 2'b00;
    rbIn      = 128'd0;
    forever begin
      @(negedge clk);
      if (cmdPending === 1'b1) begin
        if (pendCount < 16) begin
          pendEdge[pendCount] = sdEdges;
          pendCb[pendCount]   = cb;
        end
        pendCount++;
        repeat (respDelay) @(negedge clk);
        cmdStatus = timeoutAll ? 2'b01 : modelStatus;
        rbIn      = modelRb;
        if (pendCount <= 16) ackEdge[pendCount-1] = sdEdges;
        cmdAck = ~cmdAck;
      end
    end
  end

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present a request on one port at the falling edge.
  task automatic applyStimulus(input int port, input logic [5:0] idx,
                               input logic [31:0] arg, input logic [1:0] len);
    @(negedge clk);
    if (port == 0) begin
      req0Idx = idx; req0Arg = arg; req0RespLen = len; req0Valid = 1'b1;
    end else begin
      req1Idx = idx; req1Arg = arg; req1RespLen = len; req1Valid = 1'b1;
    end
  endtask

  // Clocks from the grant edge until the issue pulse is seen, bounded.
  task automatic waitPending(output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cmdPending === 1'b1) break;
    end
  endtask

  // Wait for either done pulse, bounded; reports which ports pulsed.
  task automatic waitDone(input int limit, output logic d0, output logic d1);
    int cyc;
    cyc = 0;
    d0  = 1'b0;
    d1  = 1'b0;
    while (cyc < limit) begin
      @(posedge clk);
      #1;
      cyc++;
      if (req0Done === 1'b1 || req1Done === 1'b1) begin
        d0 = req0Done;
        d1 = req1Done;
        break;
      end
    end
  endtask

  // Every output must read zero after reset.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"},     busy,       0);
    checkOutput({tag, "_cb"},       cb,         0);
    checkOutput({tag, "_pending"},  cmdPending, 0);
    checkOutput({tag, "_resplen"},  cmdRespLen, 0);
    checkOutput({tag, "_done0"},    req0Done,   0);
    checkOutput({tag, "_done1"},    req1Done,   0);
    checkOutput({tag, "_status"},   resStatus,  0);
    checkOutput({tag, "_rb"},       resRb,      0);
    checkOutput({tag, "_owner"},    resOwner,   0);
    checkOutput({tag, "_retries"},  resRetries, 0);
  endtask

  initial begin
    int   cyc;
    int   doneCount;
    logic d0;
    logic d1;

    reset = 1'b1;
    req0Valid = 1'b0; req0Idx = 6'd0; req0Arg = 32'd0; req0RespLen = 2'd0;
    req1Valid = 1'b0; req1Idx = 6'd0; req1Arg = 32'd0; req1RespLen = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // CMD0 on port 0, no response.
    $display("[TB] CMD0 on port 0");
    pendCount = 0;
    applyStimulus(0, 6'd0, 32'd0, 2'b00);
    waitPending(cyc);
    checkOutput("cmd0_latency", cyc, 41);
    checkOutput("cmd0_cb", cb, 48'h40_0000_0000_95);
    checkOutput("cmd0_busy", busy, 1);
    @(posedge clk);
    #1;
    checkOutput("cmd0_pending_width", cmdPending, 0);
    waitDone(400, d0, d1);
    checkOutput("cmd0_done0", d0, 1);
    checkOutput("cmd0_done1", d1, 0);
    checkOutput("cmd0_status", resStatus, 2'b00);
    checkOutput("cmd0_owner", resOwner, 0);
    checkOutput("cmd0_pend_count", pendCount, 1);
    req0Valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("cmd0_done_width", req0Done, 0);

    // CMD8 on port 1 with an R7 echo.
    $display("[TB] CMD8 on port 1");
    modelRb = {40'h48_0000_01AA, 88'd0};
    applyStimulus(1, 6'd8, 32'h0000_01AA, 2'b10);
    waitPending(cyc);
    checkOutput("cmd8_cb", cb, 48'h48_0000_01AA_87);
    checkOutput("cmd8_resplen", cmdRespLen, 2'b10);
    waitDone(400, d0, d1);
    checkOutput("cmd8_done1", d1, 1);
    checkOutput("cmd8_status", resStatus, 2'b00);
    checkOutput("cmd8_owner", resOwner, 1);
    checkOutput("cmd8_rb_echo", resRb[127:88], 40'h48_0000_01AA);
    checkOutput("cmd8_retries", resRetries, 0);
    req1Valid = 1'b0;

    // Every attempt times out: one issue plus three retries.
    $display("[TB] timeout retries");
    timeoutAll = 1'b1;
    pendCount  = 0;
    applyStimulus(0, 6'd13, 32'h1234_0000, 2'b10);
    waitDone(2000, d0, d1);
    checkOutput("retry_done0", d0, 1);
    checkOutput("retry_pend_count", pendCount, 4);
    for (int k = 1; k < 4; k++) begin
      checkOutput("retry_cb_stable", pendCb[k], pendCb[0]);
      checkOutput("retry_guard_gap", (pendEdge[k] - ackEdge[k-1]) >= 9, 1);
    end
    checkOutput("retry_status", resStatus, 2'b01);
    checkOutput("retry_retries", resRetries, 3);
    checkOutput("retry_owner", resOwner, 0);
    req0Valid  = 1'b0;
    timeoutAll = 1'b0;

    // CMD17 with a CRC error status: reported, not retried.
    $display("[TB] CMD17 with CRC status");
    modelStatus = 2'b11;
    pendCount   = 0;
    applyStimulus(0, 6'd17, 32'd0, 2'b10);
    waitPending(cyc);
    checkOutput("cmd17_cb", cb, 48'h51_0000_0000_55);
    waitDone(400, d0, d1);
    checkOutput("cmd17_done0", d0, 1);
    checkOutput("cmd17_status", resStatus, 2'b11);
    checkOutput("cmd17_retries", resRetries, 0);
    checkOutput("cmd17_pend_count", pendCount, 1);
    req0Valid   = 1'b0;
    modelStatus = 2'b00;

    // Reset while waiting for the ack: command dropped, no done.
    $display("[TB] reset during WAIT");
    applyStimulus(1, 6'd55, 32'd0, 2'b10);
    waitPending(cyc);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset     = 1'b1;
    req1Valid = 1'b0;
    @(posedge clk);
    #1;
    checkResetOutputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    doneCount = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (req0Done === 1'b1 || req1Done === 1'b1) doneCount++;
    end
    checkOutput("midreset_no_done", doneCount, 0);
    checkOutput("midreset_idle", busy, 0);

    // Tie after reset: port 1 first; port 1 stays valid, so port 0 wins the
    // next tie, then port 1 again.
    $display("[TB] arbitration ties");
    modelRb = 128'h0;
    @(negedge clk);
    req0Idx = 6'd13; req0Arg = 32'h0001_0000; req0RespLen = 2'b10; req0Valid = 1'b1;
    req1Idx = 6'd12; req1Arg = 32'd0;         req1RespLen = 2'b10; req1Valid = 1'b1;
    waitDone(400, d0, d1);
    checkOutput("tie1_done1", d1, 1);
    checkOutput("tie1_done0", d0, 0);
    checkOutput("tie1_status", resStatus, 2'b00);
    checkOutput("tie1_owner", resOwner, 1);
    waitDone(400, d0, d1);
    checkOutput("tie2_done0", d0, 1);
    checkOutput("tie2_done1", d1, 0);
    checkOutput("tie2_owner", resOwner, 0);
    req0Valid = 1'b0;
    waitDone(400, d0, d1);
    checkOutput("tie3_done1", d1, 1);
    checkOutput("tie3_owner", resOwner, 1);
    req1Valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
